sram_pkt_fetch: RTL and testbench
=================================

SRAM_PKT_FETCH -- requirements
Module: sram_pkt_fetch

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 2: cycles from sram_read pulse to valid sram_data.
REQ-002 The block SHALL have parameter MAX_LEN, default 255: largest legal payload length in bytes.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port sram_read, output, 1 bit: one-cycle read strobe to the SRAM FIFO master port.
REQ-006 The block SHALL have port sram_hint, input, 1 bit: SRAM access granted to this side.
REQ-007 The block SHALL have port sram_empty, input, 1 bit: TX FIFO empty.
REQ-008 The block SHALL have port sram_data, input, 16 bits: word read from the FIFO.
REQ-009 The block SHALL have port byte_out, output, 8 bits: payload byte to the radio TX writer.
REQ-010 The block SHALL have port byte_valid, output, 1 bit: byte_out holds a valid byte.
REQ-011 The block SHALL have port byte_ready, input, 1 bit: consumer accepts byte_out this cycle.
REQ-012 The block SHALL have port pkt_start, output, 1 bit: one-cycle pulse when a header is accepted.
REQ-013 The block SHALL have port pkt_len, output, 11 bits: byte length of the current packet.
REQ-014 The block SHALL have port pkt_done, output, 1 bit: one-cycle pulse after the last byte handshake.
REQ-015 The block SHALL have port pkt_drop, output, 1 bit: one-cycle pulse when a packet is discarded.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The block SHALL implement states IDLE, HDR_RD, HDR_WAIT, PAY_RD, PAY_WAIT, BYTE_HI, BYTE_LO, DROP, DONE.
REQ-018 The block SHALL pulse sram_read only in HDR_RD or PAY_RD, only when sram_hint=1 and sram_empty=0; otherwise it SHALL hold in that state.
REQ-019 The block SHALL sample sram_data exactly RD_LAT cycles after each sram_read pulse, in HDR_WAIT or PAY_WAIT, with one read outstanding at most.
REQ-020 The header word SHALL carry the length in bits[10:0]; bits[15:11] SHALL be ignored.
REQ-021 On a header accepted with length L, the block SHALL load pkt_len=L and pulse pkt_start in the same cycle, then enter PAY_RD.
REQ-022 The block SHALL read ceil(L/2) payload words and present bits[15:8] in BYTE_HI, then bits[7:0] in BYTE_LO.
REQ-023 For odd L, the low byte of the final word SHALL be discarded without being presented.
REQ-024 byte_valid SHALL be high only in BYTE_HI and BYTE_LO.
REQ-025 byte_out SHALL hold stable while byte_valid=1 and byte_ready=0.
REQ-026 A byte SHALL be transferred when byte_valid and byte_ready are both high, and the block SHALL advance on the next edge.
REQ-027 After the L-th byte handshake, the block SHALL enter DONE, pulse pkt_done for one cycle, and return to IDLE.
REQ-028 IDLE SHALL advance to HDR_RD when sram_empty=0.
REQ-029 A mid-packet sram_empty=1 or sram_hint=0 SHALL stall in PAY_RD with no timeout, with byte_valid=0.
REQ-030 A byte count SHALL track bytes transferred, 11 bits wide, and SHALL never wrap within a packet.

Reset
REQ-031 While reset=1, on the clock edge, the block SHALL enter IDLE and clear sram_read, byte_valid, pkt_start, pkt_done, pkt_drop, busy, byte_out and pkt_len to 0.
REQ-032 A reset mid-packet SHALL abandon the packet with no pkt_done or pkt_drop.
REQ-033 Read data returning after a mid-packet reset SHALL be ignored.

Configuration
REQ-034 The macro PKT_LEN_CHECK_EN SHALL control length checking.
REQ-035 When PKT_LEN_CHECK_EN is defined, a header with L=0 or L>MAX_LEN SHALL enter DROP instead of starting a packet.
REQ-036 In DROP, the block SHALL read and discard ceil(L/2) words, present no bytes, pulse pkt_drop once, return to IDLE, and SHALL NOT pulse pkt_start.
REQ-037 When PKT_LEN_CHECK_EN is not defined, all lengths 0..2047 SHALL be accepted.
REQ-038 When PKT_LEN_CHECK_EN is not defined, L=0 SHALL pulse pkt_start, then pkt_done on the next cycle, with no payload reads.

Verification
REQ-039 The bench SHALL cover: FIFO holds 0x0004,0xA1B2,0xC3D4, byte_ready=1 -> pkt_start with pkt_len=4; bytes A1,B2,C3,D4; one pkt_done; exactly 3 sram_read pulses.
REQ-040 The bench SHALL cover: header 0x0003, words 0x1122,0x3344 -> bytes 11,22,33 only; pkt_done after 33.
REQ-041 The bench SHALL cover: byte_ready low for 5 cycles on byte 2 -> byte_out held at B2 with byte_valid=1 throughout, no loss.
REQ-042 The bench SHALL cover: sram_hint=0 for 10 cycles mid-payload -> no sram_read, byte_valid=0, then resume with the correct next byte.
REQ-043 The bench SHALL cover: with PKT_LEN_CHECK_EN defined, header 0x0100 (256) and MAX_LEN=255 -> 128 reads, one pkt_drop, no bytes; the next good packet is delivered.
REQ-044 The bench SHALL cover: reset asserted after byte 1 of a 4-byte packet -> all outputs 0 next cycle; the following packet is parsed from a fresh header.

Source files
------------

// File: rtl/sram_pkt_fetch.sv
// Fetches length-prefixed packets from a 16-bit SRAM TX FIFO and streams payload bytes (high byte first).
// Define PKT_LEN_CHECK_EN to drop packets whose header length is 0 or above MAX_LEN.
module sram_pkt_fetch #(
  parameter int RD_LAT  = 2,
  parameter int MAX_LEN = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        sram_read,
  input  logic        sram_hint,
  input  logic        sram_empty,
  input  logic [15:0] sram_data,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        pkt_start,
  output logic [10:0] pkt_len,
  output logic        pkt_done,
  output logic        pkt_drop,
  output logic        busy
);

  localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

`ifdef PKT_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, HDR_RD, HDR_WAIT, PAY_RD, PAY_WAIT, BYTE_HI, BYTE_LO, DROP, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [10:0]      byte_cnt_q, byte_cnt_d;
  logic [10:0]      words_left_q, words_left_d;
  logic [15:0]      word_q, word_d;
  logic [10:0]      pkt_len_q, pkt_len_d;
  logic             pkt_start_q, pkt_start_d;

  logic        can_rd;
  logic        lat_hit;
  logic [10:0] hdr_len;
  logic [10:0] hdr_words;
  logic        len_bad;
  logic [10:0] byte_cnt_inc;

  assign can_rd       = sram_hint && !sram_empty;
  assign lat_hit      = (lat_q == LAT_LAST);
  assign hdr_len      = sram_data[10:0];
  assign hdr_words    = 11'((12'(hdr_len) + 12'd1) >> 1);
  assign len_bad      = LEN_CHECK && ((hdr_len == 11'd0) || (int'(hdr_len) > MAX_LEN));
  assign byte_cnt_inc = byte_cnt_q + 11'd1;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    pkt_len_d    = pkt_len_q;
    pkt_start_d  = 1'b0;
    sram_read    = 1'b0;
    pkt_drop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!sram_empty) state_d = HDR_RD;
      end
      HDR_RD: begin
        if (can_rd) begin
          sram_read = 1'b1;
          lat_d     = LAT_ONE;
          state_d   = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        if (lat_hit) begin
          lat_d        = '0;
          byte_cnt_d   = '0;
          words_left_d = hdr_words;
          if (len_bad) begin
            state_d = DROP;
          end else begin
            pkt_len_d   = hdr_len;
            pkt_start_d = 1'b1;
            state_d     = PAY_RD;
          end
        end else begin
          lat_d = lat_q + LAT_ONE;
        end
      end
      PAY_RD: begin
        // Only a zero-length packet can reach here with every byte already sent.
        if (byte_cnt_q == pkt_len_q) begin
          state_d = DONE;
        end else if (can_rd) begin
          sram_read = 1'b1;
          lat_d     = LAT_ONE;
          state_d   = PAY_WAIT;
        end
      end
      PAY_WAIT: begin
        if (lat_hit) begin
          lat_d   = '0;
          word_d  = sram_data;
          state_d = BYTE_HI;
        end else begin
          lat_d = lat_q + LAT_ONE;
        end
      end
      BYTE_HI: begin
        if (byte_ready) begin
          byte_cnt_d = byte_cnt_inc;
          state_d    = (byte_cnt_inc == pkt_len_q) ? DONE : BYTE_LO;
        end
      end
      BYTE_LO: begin
        if (byte_ready) begin
          byte_cnt_d = byte_cnt_inc;
          state_d    = (byte_cnt_inc == pkt_len_q) ? DONE : PAY_RD;
        end
      end
      DROP: begin
        // lat_q == 0 means no read is in flight; otherwise wait out the latency and discard.
        if (lat_q == '0) begin
          if (words_left_q == 11'd0) begin
            pkt_drop = 1'b1;
            state_d  = IDLE;
          end else if (can_rd) begin
            sram_read = 1'b1;
            lat_d     = LAT_ONE;
          end
        end else if (lat_hit) begin
          lat_d        = '0;
          words_left_d = words_left_q - 11'd1;
        end else begin
          lat_d = lat_q + LAT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      pkt_len_q    <= '0;
      pkt_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      pkt_len_q    <= pkt_len_d;
      pkt_start_q  <= pkt_start_d;
    end
  end

  assign byte_valid = (state_q == BYTE_HI) || (state_q == BYTE_LO);
  assign byte_out   = (state_q == BYTE_HI) ? word_q[15:8] :
                      (state_q == BYTE_LO) ? word_q[7:0]  : 8'd0;
  assign pkt_start  = pkt_start_q;
  assign pkt_len    = pkt_len_q;
  assign pkt_done   = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_pkt_fetch.sv
// Bench for sram_pkt_fetch: FIFO/SRAM model with fixed read latency, packet-level reference model.
module tb_sram_pkt_fetch;

  localparam int RD_LAT  = 2;
  localparam int MAX_LEN = 255;

`ifdef PKT_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_read;
  logic        sram_hint = 1'b1;
  logic        sram_empty = 1'b1;
  logic [15:0] sram_data = 16'hDEAD;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        pkt_start;
  logic [10:0] pkt_len;
  logic        pkt_done;
  logic        pkt_drop;
  logic        busy;

  sram_pkt_fetch #(.RD_LAT(RD_LAT), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .sram_read(sram_read), .sram_hint(sram_hint),
    .sram_empty(sram_empty), .sram_data(sram_data), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pkt_start(pkt_start),
    .pkt_len(pkt_len), .pkt_done(pkt_done), .pkt_drop(pkt_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [15:0] fifo[$];
  logic [15:0] wq[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got[$];

  int cyc = 0, rd_count = 0, start_count = 0, done_count = 0, drop_count = 0;
  int start_cyc = 0, done_cyc = 0, last_byte_cyc = 0;
  logic [10:0] start_len = '0;
  logic rd_neg = 1'b0;

  int rd_base, start_base, done_base, drop_base, got_base;
  int exp_reads, exp_len;
  bit accept;
  bit hint_rand = 1'b0, ready_rand = 1'b0;

  // Observe DUT outputs mid-cycle.
  always @(negedge clk) begin
    cyc++;
    rd_neg = sram_read;
    if (sram_read) rd_count++;
    if (pkt_start) begin start_count++; start_len = pkt_len; start_cyc = cyc; end
    if (pkt_done) begin done_count++; done_cyc = cyc; end
    if (pkt_drop) drop_count++;
    if (byte_valid && byte_ready) begin got.push_back(byte_out); last_byte_cyc = cyc; end
  end

  // FIFO read port: word valid only in the RD_LAT-th cycle after the strobe.
  initial begin
    logic [15:0] rd_word;
    int rd_age;
    rd_word = 16'h0;
    rd_age  = 0;
    forever begin
      @(posedge clk); #1;
      if (rd_neg) begin
        rd_word = (fifo.size() > 0) ? fifo.pop_front() : 16'hBAD0;
        rd_age  = 1;
      end else if (rd_age != 0 && rd_age <= RD_LAT) begin
        rd_age++;
      end
      sram_data  = (rd_age == RD_LAT) ? rd_word : 16'hDEAD;
      sram_empty = (fifo.size() == 0);
      if (hint_rand)  sram_hint  = ($urandom_range(0, 3) != 0);
      if (ready_rand) byte_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sram_read"}, 32'(sram_read), 0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 0);
    chk({tag, "_pkt_start"}, 32'(pkt_start), 0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 0);
    chk({tag, "_pkt_drop"}, 32'(pkt_drop), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_byte_out"}, 32'(byte_out), 0);
    chk({tag, "_pkt_len"}, 32'(pkt_len), 0);
  endtask

  task automatic begin_pkt();
    rd_base    = rd_count;
    start_base = start_count;
    done_base  = done_count;
    drop_base  = drop_count;
    got_base   = got.size();
    exp_q.delete();
  endtask

  // Reference model: header + ceil(L/2) words; bytes are the first L bytes, high byte first.
  task automatic load_pkt(input logic [15:0] hdr);
    int L, nw;
    logic [15:0] w;
    L  = int'(hdr[10:0]);
    nw = (L + 1) / 2;
    fifo.push_back(hdr);
    for (int i = 0; i < nw; i++) fifo.push_back(wq[i]);
    accept    = !(LEN_CHECK && (L == 0 || L > MAX_LEN));
    exp_len   = L;
    exp_reads = 1 + nw;
    if (accept) begin
      for (int i = 0; i < L; i++) begin
        w = wq[i / 2];
        exp_q.push_back((i % 2 == 0) ? w[15:8] : w[7:0]);
      end
    end
  endtask

  task automatic fill_rand(input int L);
    wq.delete();
    for (int i = 0; i < (L + 1) / 2; i++) wq.push_back(16'($urandom));
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n;
    n = 0;
    while (done_count == done_base && drop_count == drop_base && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= budget), 0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_pkt(input string tag);
    chk({tag, "_reads"}, 32'(rd_count - rd_base), 32'(exp_reads));
    chk({tag, "_starts"}, 32'(start_count - start_base), 32'(accept));
    if (accept) chk({tag, "_len"}, 32'(start_len), 32'(exp_len));
    chk({tag, "_dones"}, 32'(done_count - done_base), 32'(accept));
    chk({tag, "_drops"}, 32'(drop_count - drop_base), 32'(!accept));
    chk({tag, "_nbytes"}, 32'(got.size() - got_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_base + i < got.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(got[got_base + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic wait_bytes(input int count, input int budget, input string tag);
    int n;
    n = 0;
    while (got.size() - got_base < count && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_bytes_timeout"}, 32'(n >= budget), 0);
  endtask

  initial begin
    int n, L;
    logic [15:0] hdr;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Basic 4-byte packet
    begin_pkt();
    wq = '{16'hA1B2, 16'hC3D4};
    load_pkt(16'h0004);
    wait_end(200, "t1");
    check_pkt("t1");
    $display("t1 len4 bytes=%0d total=%0d bad=%0d", got.size() - got_base, total, bad);

    // Odd length: last low byte discarded
    begin_pkt();
    wq = '{16'h1122, 16'h3344};
    load_pkt(16'h0003);
    wait_end(200, "t2");
    check_pkt("t2");
    chk("t2_done_after_last", 32'(done_cyc - last_byte_cyc), 1);
    $display("t2 len3 bytes=%0d total=%0d bad=%0d", got.size() - got_base, total, bad);

    // Consumer backpressure on byte 2
    @(posedge clk); #1;
    byte_ready = 1'b0;
    begin_pkt();
    wq = '{16'hA1B2, 16'hC3D4};
    load_pkt(16'h0004);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!byte_valid && n < 100);
    chk("t3_valid_seen", 32'(byte_valid), 1);
    chk("t3_first_byte", 32'(byte_out), 32'hA1);
    @(posedge clk); #1;
    byte_ready = 1'b1;
    @(posedge clk); #1;
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("t3_hold_valid%0d", i), 32'(byte_valid), 1);
      chk($sformatf("t3_hold_byte%0d", i), 32'(byte_out), 32'hB2);
    end
    @(posedge clk); #1;
    byte_ready = 1'b1;
    wait_end(200, "t3");
    check_pkt("t3");
    $display("t3 stall bytes=%0d total=%0d bad=%0d", got.size() - got_base, total, bad);

    // SRAM grant withdrawn mid-payload
    begin_pkt();
    wq = '{16'h0102, 16'h0304, 16'h0506};
    load_pkt(16'h0006);
    wait_bytes(2, 200, "t4");
    sram_hint = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk($sformatf("t4_no_read%0d", i), 32'(sram_read), 0);
      chk($sformatf("t4_no_valid%0d", i), 32'(byte_valid), 0);
    end
    @(posedge clk); #1;
    sram_hint = 1'b1;
    wait_end(200, "t4");
    check_pkt("t4");
    $display("t4 hint stall bytes=%0d total=%0d bad=%0d", got.size() - got_base, total, bad);

`ifdef PKT_LEN_CHECK_EN
    // Oversized header dropped, followed by a good packet
    begin_pkt();
    fill_rand(256);
    load_pkt(16'h0100);
    wait_end(3000, "t5_big");
    check_pkt("t5_big");
    $display("t5 drop256 reads=%0d total=%0d bad=%0d", rd_count - rd_base, total, bad);
    begin_pkt();
    wq = '{16'hBEEF};
    load_pkt(16'h0002);
    wait_end(200, "t5_good");
    check_pkt("t5_good");
    begin_pkt();
    wq.delete();
    load_pkt(16'h0000);
    wait_end(200, "t5_zero");
    check_pkt("t5_zero");
    $display("t5 drop0 drops=%0d total=%0d bad=%0d", drop_count - drop_base, total, bad);
`else
    // Zero length: start then done next cycle, no payload reads
    begin_pkt();
    wq.delete();
    load_pkt(16'h0000);
    wait_end(200, "t5_zero");
    check_pkt("t5_zero");
    chk("t5_done_after_start", 32'(done_cyc - start_cyc), 1);
    $display("t5 len0 total=%0d bad=%0d", total, bad);
    begin_pkt();
    fill_rand(256);
    load_pkt(16'h0100);
    wait_end(3000, "t5_big");
    check_pkt("t5_big");
    $display("t5 len256 bytes=%0d total=%0d bad=%0d", got.size() - got_base, total, bad);
`endif

    // Header flag bits must not affect the length
    begin_pkt();
    wq = '{16'h5A6B};
    load_pkt(16'hF802);
    wait_end(200, "t6");
    check_pkt("t6");
    $display("t6 flags bytes=%0d total=%0d bad=%0d", got.size() - got_base, total, bad);

    // Reset after first byte abandons the packet
    begin_pkt();
    wq = '{16'hA1B2, 16'hC3D4};
    load_pkt(16'h0004);
    wait_bytes(1, 200, "t7");
    reset = 1'b1;
    fifo.delete();
    @(negedge clk); #1;
    check_zero("t7_rst");
    chk("t7_rst_nbytes", 32'(got.size() - got_base), 1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t7_rst_no_done", 32'(done_count - done_base), 0);
    chk("t7_rst_no_drop", 32'(drop_count - drop_base), 0);
    begin_pkt();
    wq = '{16'h5566};
    load_pkt(16'h0002);
    wait_end(200, "t7_after");
    check_pkt("t7_after");
    $display("t7 reset recovery bytes=%0d total=%0d bad=%0d", got.size() - got_base, total, bad);

    // Randomized packets with random grant and backpressure
    hint_rand  = 1'b1;
    ready_rand = 1'b1;
    for (int k = 0; k < 8; k++) begin
      L = int'($urandom_range(1, 40));
      begin_pkt();
      fill_rand(L);
      hdr = {5'($urandom), 11'(L)};
      load_pkt(hdr);
      wait_end(3000, $sformatf("r%0d", k));
      check_pkt($sformatf("r%0d", k));
      $display("r%0d len=%0d bytes=%0d total=%0d bad=%0d", k, L, got.size() - got_base, total, bad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
